// File: rtl/issue_queue_ctrl.sv
// ---------------------------------------------------------------------------
// issue_queue_ctrl
//   Instruction buffer and issue sequencer between fetch and the dual-issue
//   decode stage. Fetch writes up to two instructions per cycle into a
//   circular buffer. Decode always sees the two oldest entries and retires
//   one or two of them per cycle.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   flush_i             discard every entry (mispredict / exception)
//   stall_i             decode stall; nothing is popped this cycle
//   fetch_valid1/2_i    fetch slot valids (slot 2 needs slot 1)
//   fetch_inst1/2_i     fetch slot instructions
//   fetch_pc1/2_i       fetch slot PCs
//   issue_single_i      decode retires only the head entry this cycle
//   inst1/2_o, pc1/2_o  head and head+1 entries, zero when not valid
//   valid1/2_o          head / head+1 entry present
//   full_o              fewer than two free entries; fetch must hold
//   count_o             current occupancy
//   dual_cnt_o,
//   single_cnt_o,
//   empty_cnt_o         performance counters
//
// Build option
//   ISSUE_QUEUE_PERF_EN  builds the three performance counters. Without it
//                        the counter ports are tied to zero.
// ---------------------------------------------------------------------------
module issue_queue_ctrl #(
  parameter int DEPTH = 16,  // power of two, at least 4
  parameter int PTR_W = 4    // log2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             stall_i,
  input  logic             fetch_valid1_i,
  input  logic             fetch_valid2_i,
  input  logic [31:0]      fetch_inst1_i,
  input  logic [31:0]      fetch_inst2_i,
  input  logic [31:0]      fetch_pc1_i,
  input  logic [31:0]      fetch_pc2_i,
  input  logic             issue_single_i,
  output logic [31:0]      inst1_o,
  output logic [31:0]      inst2_o,
  output logic [31:0]      pc1_o,
  output logic [31:0]      pc2_o,
  output logic             valid1_o,
  output logic             valid2_o,
  output logic             full_o,
  output logic [PTR_W:0]   count_o,
  output logic [31:0]      dual_cnt_o,
  output logic [31:0]      single_cnt_o,
  output logic [31:0]      empty_cnt_o
);

  localparam int CNT_W = PTR_W + 1;

  // Entry storage. Contents are never reset; valid flags gate the outputs.
  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic             valid1;
  logic             valid2;
  logic             full;
  logic [1:0]       push_n;
  logic [1:0]       pop_n;
  logic             wr1_en;
  logic             wr2_en;

  // Pointers are PTR_W bits wide, so modulo-DEPTH wrap is free.
  always_comb begin
    head_p1 = head_q + PTR_W'(1);
    tail_p1 = tail_q + PTR_W'(1);
    valid1  = (count_q != '0);
    valid2  = (count_q >= CNT_W'(2));
    // DEPTH - count < 2  <=>  count >= DEPTH - 1
    full    = (count_q >= CNT_W'(DEPTH - 1));
  end

  // Push/pop amounts for this cycle (before flush override).
  always_comb begin
    push_n = 2'd0;
    if (!full && fetch_valid1_i) begin
      push_n = fetch_valid2_i ? 2'd2 : 2'd1;
    end

    pop_n = 2'd0;
    if (!stall_i && valid1) begin
      pop_n = (issue_single_i || !valid2) ? 2'd1 : 2'd2;
    end
  end

  // Next-state: flush wins over push and pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    wr1_en  = 1'b0;
    wr2_en  = 1'b0;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_n);
      tail_d  = tail_q + PTR_W'(push_n);
      count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
      wr1_en  = (push_n != 2'd0);
      wr2_en  = (push_n == 2'd2);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry writes; no reset so the arrays map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (wr1_en && !rst) begin
      inst_mem[tail_q] <= fetch_inst1_i;
      pc_mem[tail_q]   <= fetch_pc1_i;
    end
    if (wr2_en && !rst) begin
      inst_mem[tail_p1] <= fetch_inst2_i;
      pc_mem[tail_p1]   <= fetch_pc2_i;
    end
  end

  // Outputs come from registered state only, so a pushed entry shows up no
  // earlier than the cycle after it is written.
  always_comb begin
    inst1_o  = valid1 ? inst_mem[head_q]  : 32'd0;
    pc1_o    = valid1 ? pc_mem[head_q]    : 32'd0;
    inst2_o  = valid2 ? inst_mem[head_p1] : 32'd0;
    pc2_o    = valid2 ? pc_mem[head_p1]   : 32'd0;
    valid1_o = valid1;
    valid2_o = valid2;
    full_o   = full;
    count_o  = count_q;
  end

`ifdef ISSUE_QUEUE_PERF_EN
  logic [31:0] dual_cnt_q,   dual_cnt_d;
  logic [31:0] single_cnt_q, single_cnt_d;
  logic [31:0] empty_cnt_q,  empty_cnt_d;

  // A flush cancels the pop, so it is not counted as one. Counters wrap and
  // survive flush; only rst clears them.
  always_comb begin
    dual_cnt_d   = dual_cnt_q;
    single_cnt_d = single_cnt_q;
    empty_cnt_d  = empty_cnt_q;
    if (!flush_i && pop_n == 2'd2) dual_cnt_d   = dual_cnt_q + 32'd1;
    if (!flush_i && pop_n == 2'd1) single_cnt_d = single_cnt_q + 32'd1;
    if (count_q == '0 && !stall_i) empty_cnt_d  = empty_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dual_cnt_q   <= '0;
      single_cnt_q <= '0;
      empty_cnt_q  <= '0;
    end else begin
      dual_cnt_q   <= dual_cnt_d;
      single_cnt_q <= single_cnt_d;
      empty_cnt_q  <= empty_cnt_d;
    end
  end

  assign dual_cnt_o   = dual_cnt_q;
  assign single_cnt_o = single_cnt_q;
  assign empty_cnt_o  = empty_cnt_q;
`else
  assign dual_cnt_o   = 32'd0;
  assign single_cnt_o = 32'd0;
  assign empty_cnt_o  = 32'd0;
`endif

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_issue_queue_ctrl
//   Self-checking bench for issue_queue_ctrl (DEPTH=16). A queue-based
//   reference model holds the expected entries; each cycle's stimulus
//   updates it and the DUT outputs are compared against its front entries.
//   A table of vectors covers the basic push/pop cases, followed by
//   hand-written sequences for full, wrap, flush and performance counters.
// ---------------------------------------------------------------------------
module tb_issue_queue_ctrl;

  localparam int DEPTH = 16;
  localparam int PTR_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush_i;
  logic             stall_i;
  logic             fetch_valid1_i;
  logic             fetch_valid2_i;
  logic [31:0]      fetch_inst1_i;
  logic [31:0]      fetch_inst2_i;
  logic [31:0]      fetch_pc1_i;
  logic [31:0]      fetch_pc2_i;
  logic             issue_single_i;
  logic [31:0]      inst1_o, inst2_o, pc1_o, pc2_o;
  logic             valid1_o, valid2_o, full_o;
  logic [PTR_W:0]   count_o;
  logic [31:0]      dual_cnt_o, single_cnt_o, empty_cnt_o;

  issue_queue_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush_i),
    .stall_i        (stall_i),
    .fetch_valid1_i (fetch_valid1_i),
    .fetch_valid2_i (fetch_valid2_i),
    .fetch_inst1_i  (fetch_inst1_i),
    .fetch_inst2_i  (fetch_inst2_i),
    .fetch_pc1_i    (fetch_pc1_i),
    .fetch_pc2_i    (fetch_pc2_i),
    .issue_single_i (issue_single_i),
    .inst1_o        (inst1_o),
    .inst2_o        (inst2_o),
    .pc1_o          (pc1_o),
    .pc2_o          (pc2_o),
    .valid1_o       (valid1_o),
    .valid2_o       (valid2_o),
    .full_o         (full_o),
    .count_o        (count_o),
    .dual_cnt_o     (dual_cnt_o),
    .single_cnt_o   (single_cnt_o),
    .empty_cnt_o    (empty_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  typedef struct {
    bit          f, s, v1, v2, sg;
    logic [31:0] i1, p1, i2, p2;
    int          exp_cnt;
  } vec_t;

  entry_t      mq[$];
  logic [31:0] m_dual, m_single, m_empty;
  int          n_vec  = 0;
  int          n_miss = 0;
  int          step_no = 0;
  logic [31:0] pc_gen;
  vec_t        vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (step %0d)", name, act, exp, step_no);
    end
  endtask

  // Compare every DUT output against the reference model.
  task automatic check_model();
    entry_t e0, e1;
    e0 = '{inst: 32'd0, pc: 32'd0};
    e1 = '{inst: 32'd0, pc: 32'd0};
    if (mq.size() > 0) e0 = mq[0];
    if (mq.size() > 1) e1 = mq[1];
    check("count",  32'(count_o),  32'(mq.size()));
    check("valid1", 32'(valid1_o), 32'(mq.size() >= 1));
    check("valid2", 32'(valid2_o), 32'(mq.size() >= 2));
    check("full",   32'(full_o),   32'((DEPTH - mq.size()) < 2));
    check("inst1",  inst1_o, e0.inst);
    check("pc1",    pc1_o,   e0.pc);
    check("inst2",  inst2_o, e1.inst);
    check("pc2",    pc2_o,   e1.pc);
`ifdef ISSUE_QUEUE_PERF_EN
    check("dual_cnt",   dual_cnt_o,   m_dual);
    check("single_cnt", single_cnt_o, m_single);
    check("empty_cnt",  empty_cnt_o,  m_empty);
`else
    check("dual_cnt",   dual_cnt_o,   32'd0);
    check("single_cnt", single_cnt_o, 32'd0);
    check("empty_cnt",  empty_cnt_o,  32'd0);
`endif
  endtask

  // One clock cycle: drive inputs, let the edge happen, update the model
  // from the pre-edge occupancy, then compare 1 time unit after the edge.
  task automatic step(input bit r, input bit f, input bit s, input bit v1, input bit v2,
                      input bit sg, input logic [31:0] i1, input logic [31:0] p1,
                      input logic [31:0] i2, input logic [31:0] p2);
    int sz;
    int pop;
    rst = r; flush_i = f; stall_i = s;
    fetch_valid1_i = v1; fetch_valid2_i = v2; issue_single_i = sg;
    fetch_inst1_i = i1; fetch_pc1_i = p1; fetch_inst2_i = i2; fetch_pc2_i = p2;
    @(posedge clk);
    sz = mq.size();
    if (r) begin
      mq.delete();
      m_dual = 0; m_single = 0; m_empty = 0;
    end else begin
      if (sz == 0 && !s) m_empty++;
      if (f) begin
        mq.delete();
      end else begin
        pop = (s || sz == 0) ? 0 : ((sg || sz < 2) ? 1 : 2);
        if (pop == 2) m_dual++;
        if (pop == 1) m_single++;
        for (int k = 0; k < pop; k++) void'(mq.pop_front());
        if ((DEPTH - sz) >= 2 && v1) begin
          mq.push_back('{inst: i1, pc: p1});
          if (v2) mq.push_back('{inst: i2, pc: p2});
        end
      end
    end
    #1;
    step_no++;
    $display("step %0d: rst=%0b flush=%0b stall=%0b fv=%0b%0b single=%0b -> count=%0d v=%0b%0b full=%0b pc1=%08h",
             step_no, r, f, s, v1, v2, sg, count_o, valid1_o, valid2_o, full_o, pc1_o);
    check_model();
  endtask

  task automatic idle(input bit s, input bit sg);
    step(1'b0, 1'b0, s, 1'b0, 1'b0, sg, 32'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Push one or two generated instructions with sequential PCs.
  task automatic push_gen(input bit two, input bit s, input bit sg);
    step(1'b0, 1'b0, s, 1'b1, two, sg, 32'h1000_0000 ^ pc_gen, pc_gen,
         32'h1000_0000 ^ (pc_gen + 32'd4), pc_gen + 32'd4);
    pc_gen = pc_gen + (two ? 32'd8 : 32'd4);
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; stall_i = 1'b0;
    fetch_valid1_i = 1'b0; fetch_valid2_i = 1'b0; issue_single_i = 1'b0;
    fetch_inst1_i = '0; fetch_inst2_i = '0; fetch_pc1_i = '0; fetch_pc2_i = '0;
    m_dual = 0; m_single = 0; m_empty = 0;

    // Basic vectors: {flush, stall, fv1, fv2, single, inst1, pc1, inst2, pc2, count after}
    vecs[0] = '{0, 0, 1, 1, 0, 32'h24010001, 32'hBFC00000, 32'h24020002, 32'hBFC00004, 2};
    vecs[1] = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0};
    vecs[2] = '{0, 1, 1, 1, 0, 32'h2403000A, 32'hBFC00010, 32'h2404000B, 32'hBFC00014, 2};
    vecs[3] = '{0, 1, 1, 0, 0, 32'h2405000C, 32'hBFC00018, 32'hFFFFFFFF, 32'hFFFFFFFF, 3};
    vecs[4] = '{0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        2};
    vecs[5] = '{0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h0,        32'h0,        1};
    vecs[6] = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        0};
    vecs[7] = '{0, 1, 0, 1, 0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 0};

    // Reset
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA, 32'hB, 32'hC, 32'hD);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    check("rst_count",  32'(count_o),  32'd0);
    check("rst_valid1", 32'(valid1_o), 32'd0);
    check("rst_full",   32'(full_o),   32'd0);
    check("rst_pc1",    pc1_o,         32'd0);

    // Table-driven basic push/pop cases
    for (int v = 0; v < 8; v++) begin
      step(1'b0, vecs[v].f, vecs[v].s, vecs[v].v1, vecs[v].v2, vecs[v].sg,
           vecs[v].i1, vecs[v].p1, vecs[v].i2, vecs[v].p2);
      check($sformatf("tbl%0d_count", v), 32'(count_o), 32'(vecs[v].exp_cnt));
      if (v == 0) begin
        check("tbl0_inst1", inst1_o, 32'h24010001);
        check("tbl0_pc2",   pc2_o,   32'hBFC00004);
      end
      if (v == 4) check("tbl4_inst1", inst1_o, 32'h2404000B);
      if (v == 5) check("tbl5_inst1", inst1_o, 32'h2405000C);
    end

    // Fill to 15 without popping, then a dropped push, then one pop
    pc_gen = 32'hBFC00000;
    for (int k = 0; k < 7; k++) push_gen(1'b1, 1'b1, 1'b0);
    push_gen(1'b0, 1'b1, 1'b0);
    check("fill_count", 32'(count_o), 32'd15);
    check("fill_full",  32'(full_o),  32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'hBAD0BAD0, 32'hBAD0BAD0, 32'hBAD1BAD1, 32'hBAD1BAD1);
    check("drop_count", 32'(count_o), 32'd15);
    idle(1'b0, 1'b1);
    check("pop1_count", 32'(count_o), 32'd14);
    check("pop1_full",  32'(full_o),  32'd0);
    check("pop1_pc1",   pc1_o,        32'hBFC00004);

    // Pointer wrap: push 2 / pop 2 for 20 cycles
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    pc_gen = 32'hBFC00000;
    push_gen(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 20; k++) begin
      push_gen(1'b1, 1'b0, 1'b0);
      check("wrap_count", 32'(count_o), 32'd2);
      check("wrap_pc1",   pc1_o, 32'hBFC00000 + 32'(8 * (k + 1)));
      check("wrap_pc2",   pc2_o, 32'hBFC00004 + 32'(8 * (k + 1)));
    end

    // Flush with five entries present and a simultaneous push
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    push_gen(1'b1, 1'b1, 1'b0);
    push_gen(1'b1, 1'b1, 1'b0);
    push_gen(1'b0, 1'b1, 1'b0);
    check("pre_flush_count", 32'(count_o), 32'd5);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF);
    check("flush_count",  32'(count_o),  32'd0);
    check("flush_valid1", 32'(valid1_o), 32'd0);
    idle(1'b1, 1'b0);
    check("flush_pc1", pc1_o, 32'd0);

    // Performance counters: 3 dual pops, 2 single pops, 4 empty cycles
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    pc_gen = 32'hBFC00000;
    for (int k = 0; k < 4; k++) push_gen(1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) idle(1'b0, 1'b0);
    for (int k = 0; k < 2; k++) idle(1'b0, 1'b1);
    for (int k = 0; k < 4; k++) idle(1'b0, 1'b0);
`ifdef ISSUE_QUEUE_PERF_EN
    check("perf_dual",   dual_cnt_o,   32'd3);
    check("perf_single", single_cnt_o, 32'd2);
    check("perf_empty",  empty_cnt_o,  32'd4);
`else
    check("perf_dual",   dual_cnt_o,   32'd0);
    check("perf_single", single_cnt_o, 32'd0);
    check("perf_empty",  empty_cnt_o,  32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
